// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control unit: Moore FSM that sequences fetch, decode and execute of lw/sw/R-type/beq/addi/j.
// Optional ORI support is compiled in when MIPS_CTRL_ORI_EN is defined.
module mips_multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       ExtZero,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    ALUWB   = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    IMMWB   = 4'd10,
    JEX     = 4'd11,
    ORIEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state, state_next;
  logic   pcwrite, branch;

  // NOTE: reset is synchronous, so it only takes effect on a clock edge; state uses <= so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // NOTE: every output gets a default before the case, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = FETCH;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    PCSrc      = 2'b00;
    ExtZero    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;

    case (state)
      FETCH: begin
        IRWrite    = 1'b1;
        pcwrite    = 1'b1;
        ALUSrcB    = 2'b01;
        state_next = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = RTYPEEX;
          OP_BEQ:       state_next = BEQEX;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JEX;
`ifdef MIPS_CTRL_ORI_EN
          OP_ORI:       state_next = ORIEX;
`endif
          default:      state_next = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = (Op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        IorD       = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      RTYPEEX: begin
        ALUSrcA = 1'b1;
        case (Funct)
          6'b100000: ALUControl = ALU_ADD;
          6'b100010: ALUControl = ALU_SUB;
          6'b100100: ALUControl = ALU_AND;
          6'b100101: ALUControl = ALU_OR;
          6'b101010: ALUControl = ALU_SLT;
          default:   ALUControl = ALU_ADD;
        endcase
        state_next = ALUWB;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BEQEX: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        branch     = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = IMMWB;
      end
      IMMWB: begin
        RegWrite = 1'b1;
      end
      JEX: begin
        PCSrc   = 2'b10;
        pcwrite = 1'b1;
      end
`ifdef MIPS_CTRL_ORI_EN
      ORIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = ALU_OR;
        ExtZero    = 1'b1;
        state_next = IMMWB;
      end
`endif
      default: state_next = FETCH;
    endcase
  end

  // Branch is taken in the same cycle the ALU compares the operands.
  assign PCEn  = pcwrite | (branch & Zero);
  assign State = state;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed bench for mips_multicycle_controller: walks each instruction class through its state
// sequence and compares State plus every control output against hand-derived expectations.
module tb_mips_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] PCSrc;
  logic       PCEn, ExtZero;
  logic [3:0] State;

  int checks = 0;
  int passed = 0;

  mips_multicycle_controller dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .PCSrc(PCSrc), .PCEn(PCEn), .ExtZero(ExtZero), .State(State)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Packed order: IorD MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA ALUSrcB ALUControl PCSrc PCEn ExtZero
  function automatic logic [16:0] ctrl_word();
    return {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
            ALUSrcB, ALUControl, PCSrc, PCEn, ExtZero};
  endfunction

  function automatic logic [16:0] mk(input logic iord, mw, irw, rd, m2r, rw, sa,
                                     input logic [1:0] sb, input logic [2:0] alu,
                                     input logic [1:0] pcs, input logic pcen, ez);
    return {iord, mw, irw, rd, m2r, rw, sa, sb, alu, pcs, pcen, ez};
  endfunction

  // Expected outputs per state, taken from the state output table.
  function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic [5:0] fn, input logic z);
    logic [2:0] ralu;
    case (fn)
      6'b100000: ralu = 3'b010;
      6'b100010: ralu = 3'b110;
      6'b100100: ralu = 3'b000;
      6'b100101: ralu = 3'b001;
      6'b101010: ralu = 3'b111;
      default:   ralu = 3'b010;
    endcase
    case (st)
      4'd0:  return mk(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0);
      4'd1:  return mk(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0);
      4'd2:  return mk(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0);
      4'd3:  return mk(1,0,0,0,0,0,0,2'b00,3'b010,2'b00,0,0);
      4'd4:  return mk(0,0,0,0,1,1,0,2'b00,3'b010,2'b00,0,0);
      4'd5:  return mk(1,1,0,0,0,0,0,2'b00,3'b010,2'b00,0,0);
      4'd6:  return mk(0,0,0,0,0,0,1,2'b00,ralu,  2'b00,0,0);
      4'd7:  return mk(0,0,0,1,0,1,0,2'b00,3'b010,2'b00,0,0);
      4'd8:  return mk(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,z,0);
      4'd9:  return mk(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0);
      4'd10: return mk(0,0,0,0,0,1,0,2'b00,3'b010,2'b00,0,0);
      4'd11: return mk(0,0,0,0,0,0,0,2'b00,3'b010,2'b10,1,0);
      4'd12: return mk(0,0,0,0,0,0,1,2'b10,3'b001,2'b00,0,1);
      default: return '0;
    endcase
  endfunction

  // Called just after a rising edge with the FSM in FETCH. seq holds one state per nibble,
  // first state in the lowest nibble; n states are walked, then FETCH must follow.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input logic [31:0] seq, input int n);
    logic [3:0] st;
    Op = op; Funct = fn; Zero = z;
    for (int i = 0; i < n; i++) begin
      st = seq[4*i +: 4];
      @(negedge clk);
      check($sformatf("%s state[%0d]", name, i), 32'(State), 32'(st));
      check($sformatf("%s ctrl[%0d]", name, i), 32'(ctrl_word()), 32'(exp_ctrl(st, fn, z)));
      @(posedge clk); #1;
    end
    check($sformatf("%s return", name), 32'(State), 32'd0);
  endtask

  initial begin
    reset = 1'b1; Op = 6'b111111; Funct = '0; Zero = 1'b1;
    // Start from the middle of nowhere: reset must force FETCH.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset state", 32'(State), 32'd0);
    check("reset ctrl", 32'(ctrl_word()), 32'(mk(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0)));
    @(posedge clk); #1;
    // One FETCH->DECODE->FETCH trip with Op=111111 puts us back in FETCH just after an edge.
    check("unk-pre state", 32'(State), 32'd1);
    @(posedge clk); #1;

    run_instr("lw",       6'b100011, 6'b000000, 1'b1, 32'h0004_3210, 5);
    run_instr("sw",       6'b101011, 6'b000000, 1'b1, 32'h0000_5210, 4);
    run_instr("r-add",    6'b000000, 6'b100000, 1'b1, 32'h0000_7610, 4);
    run_instr("r-sub",    6'b000000, 6'b100010, 1'b1, 32'h0000_7610, 4);
    run_instr("r-and",    6'b000000, 6'b100100, 1'b0, 32'h0000_7610, 4);
    run_instr("r-or",     6'b000000, 6'b100101, 1'b0, 32'h0000_7610, 4);
    run_instr("r-slt",    6'b000000, 6'b101010, 1'b1, 32'h0000_7610, 4);
    run_instr("r-unk",    6'b000000, 6'b111111, 1'b1, 32'h0000_7610, 4);
    run_instr("addi",     6'b001000, 6'b000000, 1'b1, 32'h0000_A910, 4);
    run_instr("beq-take", 6'b000100, 6'b000000, 1'b1, 32'h0000_0810, 3);
    run_instr("beq-not",  6'b000100, 6'b000000, 1'b0, 32'h0000_0810, 3);
    run_instr("j",        6'b000010, 6'b000000, 1'b0, 32'h0000_0B10, 3);
`ifdef MIPS_CTRL_ORI_EN
    run_instr("ori",      6'b001101, 6'b000000, 1'b1, 32'h0000_AC10, 4);
`else
    run_instr("ori-off",  6'b001101, 6'b000000, 1'b1, 32'h0000_0010, 2);
`endif
    run_instr("op-ff",    6'b111111, 6'b000000, 1'b1, 32'h0000_0010, 2);

    // Reset while in MEMRD must abandon the load before any writeback.
    Op = 6'b100011; Funct = '0; Zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst-lw regwrite[%0d]", i), 32'(RegWrite), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("rst-lw in memrd", 32'(State), 32'd3);
    check("rst-lw memrd regwrite", 32'(RegWrite), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst-lw state", 32'(State), 32'd0);
    check("rst-lw post regwrite", 32'(RegWrite), 32'd0);
    check("rst-lw post ctrl", 32'(ctrl_word()), 32'(mk(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0)));

    // Normal operation resumes cleanly after the aborted load.
    run_instr("lw-after", 6'b100011, 6'b000000, 1'b0, 32'h0004_3210, 5);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
